// File: rtl/fetch_align_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_align_ctrl : word-aligned IMEM fetcher with a halfword aligner for decode.
// Compressed (16-bit) support is enabled by defining C_EXT_EN.        Rev 1.0
// ============================================================================
module fetch_align_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_inst_o,
  output logic [31:0] out_pc_o,
  output logic        out_comp_o,
  output logic        out_illegal_o
);

  logic [31:0] wbuf_q;
  logic [31:0] wpc_q;
  logic [31:0] fpc_q;
  logic        wvalid_q;
  logic        pend_q;
  logic        drop_q;
`ifdef C_EXT_EN
  logic        off_q;
  logic        hvalid_q;
  logic [15:0] hold_q;
  logic [31:2] hpc_q;
`endif

  logic        emit;
  logic        word_last;
  logic        take_hold;
  logic        accept;
  logic        consumed;
  logic        req;
  logic        comp;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        unused_bits;

  always_comb begin
    emit      = 1'b0;
    word_last = 1'b0;
    take_hold = 1'b0;
    comp      = 1'b0;
    inst      = '0;
`ifdef C_EXT_EN
    pc        = {wpc_q[31:2], off_q, 1'b0};
    if (wvalid_q) begin
      if (hvalid_q) begin
        emit = 1'b1;
        inst = {wbuf_q[15:0], hold_q};
        pc   = {hpc_q, 2'b10};
      end else if (!off_q) begin
        emit = 1'b1;
        if (wbuf_q[1:0] != 2'b11) begin
          inst = {16'h0000, wbuf_q[15:0]};
          comp = 1'b1;
        end else begin
          inst      = wbuf_q;
          word_last = 1'b1;
        end
      end else if (wbuf_q[17:16] != 2'b11) begin
        emit      = 1'b1;
        inst      = {16'h0000, wbuf_q[31:16]};
        comp      = 1'b1;
        word_last = 1'b1;
      end else begin
        // upper half starts a straddling instruction: park it, free the word
        take_hold = 1'b1;
      end
    end
`else
    pc = wpc_q;
    if (wvalid_q) begin
      emit      = 1'b1;
      word_last = 1'b1;
      inst      = wbuf_q;
    end
`endif
  end

  assign out_valid_o   = emit && !redirect_i;
  assign accept        = out_valid_o && out_ready_i;
  assign consumed      = (accept && word_last) || (take_hold && !redirect_i);
  assign req           = !rst && !pend_q && (!wvalid_q || consumed) && !redirect_i;
  assign imem_req_o    = req;
  assign imem_addr_o   = {fpc_q[31:2], 2'b00};
  assign out_inst_o    = out_valid_o ? inst : 32'h0;
  assign out_pc_o      = pc;
  assign out_comp_o    = out_valid_o && comp;
  assign out_illegal_o = out_comp_o && (inst[15:0] == 16'h0000);
  assign unused_bits   = ^{redirect_pc_i[1:0], wpc_q[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf_q   <= '0;
      wpc_q    <= RESET_PC;
      fpc_q    <= RESET_PC;
      wvalid_q <= 1'b0;
      pend_q   <= 1'b0;
      drop_q   <= 1'b0;
`ifdef C_EXT_EN
      off_q    <= RESET_PC[1];
      hvalid_q <= 1'b0;
      hold_q   <= '0;
      hpc_q    <= '0;
`endif
    end else if (redirect_i) begin
      wvalid_q <= 1'b0;
      fpc_q    <= {redirect_pc_i[31:2], 2'b00};
      // a response landing in this very cycle is the stale one; swallow it now
      pend_q   <= pend_q && !imem_valid_i;
      drop_q   <= pend_q && !imem_valid_i;
`ifdef C_EXT_EN
      hvalid_q <= 1'b0;
      off_q    <= redirect_pc_i[1];
`endif
    end else begin
      if (req) begin
        pend_q <= 1'b1;
        fpc_q  <= fpc_q + 32'd4;
        wpc_q  <= {fpc_q[31:2], 2'b00};
      end
      if (consumed) begin
        wvalid_q <= 1'b0;
      end
      if (pend_q && imem_valid_i) begin
        pend_q <= 1'b0;
        drop_q <= 1'b0;
        if (!drop_q) begin
          wbuf_q   <= imem_rdata_i;
          wvalid_q <= 1'b1;
        end
      end
`ifdef C_EXT_EN
      if (accept) begin
        if (hvalid_q) begin
          hvalid_q <= 1'b0;
          off_q    <= 1'b1;
        end else begin
          off_q <= !word_last;
        end
      end
      if (take_hold) begin
        hold_q   <= wbuf_q[31:16];
        hpc_q    <= wpc_q[31:2];
        hvalid_q <= 1'b1;
        off_q    <= 1'b0;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_align_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fetch_align_ctrl : table-driven + scoreboard bench for fetch_align_ctrl.
// Expectations follow the C_EXT_EN setting of the build.              Rev 1.0
// ============================================================================
module tb_fetch_align_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef C_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [2:0][31:0] w;
    int               nreq;
    int               nexp;
    exp_t [3:0]       e;
  } case_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_comp;
  logic        out_illegal;

  fetch_align_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_valid_i  (imem_valid),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_inst_o    (out_inst),
    .out_pc_o      (out_pc),
    .out_comp_o    (out_comp),
    .out_illegal_o (out_illegal)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          lat = 1;
  bit          stall = 1'b0;
  bit          resp_busy = 1'b0;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = 32'h0;
  logic [31:0] req_log[$];
  exp_t        exp_q[$];
  logic [31:0] mem [bit [31:0]];
  case_t       cases [5];

  function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p,
                              input logic c, input logic il);
    exp_t x;
    x.inst = i; x.pc = p; x.comp = c; x.ill = il;
    return x;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic set_case(input int i, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input int nreq);
    cases[i].w[0] = w0; cases[i].w[1] = w1; cases[i].w[2] = w2;
    cases[i].nreq = nreq;
    cases[i].nexp = 0;
  endtask

  task automatic add_exp(input int i, input exp_t x);
    cases[i].e[cases[i].nexp] = x;
    cases[i].nexp++;
  endtask

  // One clock: drive inputs after the falling edge, sample #1 later.
  task automatic step(input logic rd = 1'b0, input logic [31:0] rpc = 32'h0);
    exp_t e;
    @(negedge clk);
    redirect    = rd;
    redirect_pc = rpc;
    imem_valid  = 1'b0;
    if (resp_busy) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = rd_mem(resp_addr);
        resp_busy  = 1'b0;
      end
    end
    out_ready = !stall && (exp_q.size() > 0);
    #1;
    if (rd) chk("redirect_no_valid", out_valid, 1'b0);
    if (imem_req) begin
      chk("one_outstanding", resp_busy, 1'b0);
      req_log.push_back(imem_addr);
      resp_busy = 1'b1;
      resp_cnt  = lat;
      resp_addr = imem_addr;
    end
    if (out_valid && out_ready) begin
      e = exp_q.pop_front();
      chk("out", {out_inst, out_pc, out_comp, out_illegal}, {e.inst, e.pc, e.comp, e.ill});
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; redirect = 1'b0; imem_valid = 1'b0; out_ready = 1'b0;
    resp_busy = 1'b0; stall = 1'b0;
    exp_q.delete(); req_log.delete();
    repeat (2) @(negedge clk);
    #1;
    chk("reset", {imem_req, out_valid, out_inst, out_pc, out_comp, out_illegal},
        {1'b0, 1'b0, 32'h0, RESET_PC, 1'b0, 1'b0});
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic run_until_empty(input int max_cycles);
    int n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t h_a, h_b, h_pend;
    int   n;

    if (EXT) begin
      set_case(0, 32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 2);
      add_exp(0, mk(32'h0000_0013, 32'h0, 1'b0, 1'b0));
      set_case(1, 32'h4501_4581, 32'h0000_0013, 32'h0000_0013, 2);
      add_exp(1, mk(32'h0000_4581, 32'h0, 1'b1, 1'b0));
      add_exp(1, mk(32'h0000_4501, 32'h2, 1'b1, 1'b0));
      set_case(2, 32'h0513_4581, 32'h0000_0000, 32'h00A0_0093, 3);
      add_exp(2, mk(32'h0000_4581, 32'h0, 1'b1, 1'b0));
      add_exp(2, mk(32'h0000_0513, 32'h2, 1'b0, 1'b0));
      add_exp(2, mk(32'h0000_0000, 32'h6, 1'b1, 1'b1));
      set_case(3, 32'h00A0_0093, 32'h0001_4501, 32'h0000_0013, 3);
      add_exp(3, mk(32'h00A0_0093, 32'h0, 1'b0, 1'b0));
      add_exp(3, mk(32'h0000_4501, 32'h4, 1'b1, 1'b0));
      add_exp(3, mk(32'h0000_0001, 32'h6, 1'b1, 1'b0));
      set_case(4, 32'h0000_0000, 32'h0000_0013, 32'h0000_0013, 2);
      add_exp(4, mk(32'h0000_0000, 32'h0, 1'b1, 1'b1));
      add_exp(4, mk(32'h0000_0000, 32'h2, 1'b1, 1'b1));
    end else begin
      set_case(0, 32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 2);
      add_exp(0, mk(32'h0000_0013, 32'h0, 1'b0, 1'b0));
      set_case(1, 32'h4501_4581, 32'h0000_0013, 32'h0000_0013, 2);
      add_exp(1, mk(32'h4501_4581, 32'h0, 1'b0, 1'b0));
      set_case(2, 32'h0513_4581, 32'h0000_0000, 32'h00A0_0093, 3);
      add_exp(2, mk(32'h0513_4581, 32'h0, 1'b0, 1'b0));
      add_exp(2, mk(32'h0000_0000, 32'h4, 1'b0, 1'b0));
      set_case(3, 32'h00A0_0093, 32'h0001_4501, 32'h0000_0013, 3);
      add_exp(3, mk(32'h00A0_0093, 32'h0, 1'b0, 1'b0));
      add_exp(3, mk(32'h0001_4501, 32'h4, 1'b0, 1'b0));
      set_case(4, 32'h0000_0000, 32'h0000_0013, 32'h0000_0013, 2);
      add_exp(4, mk(32'h0000_0000, 32'h0, 1'b0, 1'b0));
    end

    for (int i = 0; i < 5; i++) begin
      mem.delete();
      mem[32'h0] = cases[i].w[0];
      mem[32'h4] = cases[i].w[1];
      mem[32'h8] = cases[i].w[2];
      reset_dut();
      for (int j = 0; j < cases[i].nexp; j++) exp_q.push_back(cases[i].e[j]);
      run_until_empty(40);
      repeat (4) step();
      chk("req_count", req_log.size(), cases[i].nreq);
      chk("last_req_addr", (req_log.size() > 0) ? req_log[$] : 32'hDEAD_BEEF,
          32'((cases[i].nreq - 1) * 4));
    end

    // Redirect to a high-half address from an idle, non-pending state.
    mem[32'h100] = 32'h0013_0001;
    mem[32'h104] = 32'h0000_0000;
    h_a = EXT ? mk(32'h0000_0013, 32'h102, 1'b0, 1'b0) : mk(32'h0013_0001, 32'h100, 1'b0, 1'b0);
    req_log.delete();
    exp_q.push_back(h_a);
    step(1'b1, 32'h102);
    run_until_empty(30);
    chk("redirect_first_addr", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h100);

    // Back-pressure: output held stable for three cycles, no extra reads.
    mem.delete();
    mem[32'h0] = 32'h4501_4581;
    reset_dut();
    stall = 1'b1;
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    chk("stall_valid", out_valid, 1'b1);
    h_a = EXT ? mk(32'h0000_4581, 32'h0, 1'b1, 1'b0) : mk(32'h4501_4581, 32'h0, 1'b0, 1'b0);
    h_b = mk(32'h0000_4501, 32'h2, 1'b1, 1'b0);
    repeat (3) begin
      step();
      chk("stall_hold", {out_valid, out_inst, out_pc, out_comp}, {1'b1, h_a.inst, h_a.pc, h_a.comp});
      chk("stall_reqs", req_log.size(), 1);
    end
    stall = 1'b0;
    exp_q.push_back(h_a);
    if (EXT) exp_q.push_back(h_b);
    run_until_empty(20);

    // Redirect while a read is outstanding: stale data must be dropped.
    lat = 3;
    mem.delete();
    mem[32'h0]   = 32'h4501_4581;
    mem[32'h200] = 32'h0000_0013;
    reset_dut();
    step();
    chk("pend_req_seen", req_log.size(), 1);
    req_log.delete();
    exp_q.push_back(mk(32'h0000_0013, 32'h200, 1'b0, 1'b0));
    step(1'b1, 32'h200);
    run_until_empty(40);
    chk("drop_then_addr", (req_log.size() > 0) ? req_log[0] : 32'hDEAD_BEEF, 32'h200);
    lat = 1;

    // Asynchronous reset while a straddle/next output is pending.
    mem.delete();
    mem[32'h0] = 32'h0013_0001;
    mem[32'h4] = 32'h0000_0000;
    reset_dut();
    h_a    = EXT ? mk(32'h0000_0001, 32'h0, 1'b1, 1'b0) : mk(32'h0013_0001, 32'h0, 1'b0, 1'b0);
    h_pend = EXT ? mk(32'h0000_0013, 32'h2, 1'b0, 1'b0) : mk(32'h0000_0000, 32'h4, 1'b0, 1'b0);
    exp_q.push_back(h_a);
    run_until_empty(20);
    repeat (5) step();
    chk("pre_rst_pending", {out_valid, out_inst, out_pc}, {1'b1, h_pend.inst, h_pend.pc});
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {imem_req, out_valid, out_inst, out_pc, out_comp, out_illegal},
        {1'b0, 1'b0, 32'h0, RESET_PC, 1'b0, 1'b0});
    resp_busy = 1'b0;
    imem_valid = 1'b0;
    req_log.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    chk("rst_first_req", {imem_req, imem_addr}, {1'b1, RESET_PC});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
